cpu_core: RTL and testbench

Parametrised multi-cycle CPU core: next generation of the 8-bit control/ALU/register datapath. It fetches instructions from an external synchronous instruction memory and executes them through a FETCH/DECODE/EXEC state machine. It holds a REG_CNT-entry register file, Z/C flags and a PC, and emits results on a valid/ready output port. It sits between the instruction ROM and downstream consumers; widths are set by parameters.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/cpu_if.sv | 25 ++
 rtl/alu_core.sv | 49 ++++
 rtl/cpu_core.sv | 126 ++++++++++++
 tb/tb_cpu_core.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/state types, flag indices and instruction field helpers for cpu_core
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_LDI  = 4'd7,
        OP_ADDI = 4'd8,
        OP_JMP  = 4'd9,
        OP_JZ   = 4'd10,
        OP_JC   = 4'd11,
        OP_OUT  = 4'd12,
        OP_SHL  = 4'd13,
        OP_SHR  = 4'd14,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        OUT_WAIT,
        HALT
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    // Field helpers work on a zero-extended word so one set serves every parametrisation
    localparam int MAX_INSTR_W = 64;
    typedef logic [MAX_INSTR_W-1:0] instr_word_t;

    function automatic opcode_e instr_op(input instr_word_t w, input int instr_w);
        return opcode_e'(w[instr_w-4 +: 4]);
    endfunction

    function automatic instr_word_t instr_rd(input instr_word_t w, input int ra_w, input int data_w);
        return (w >> (data_w + ra_w)) & ((instr_word_t'(1) << ra_w) - instr_word_t'(1));
    endfunction

    function automatic instr_word_t instr_rs(input instr_word_t w, input int ra_w, input int data_w);
        return (w >> data_w) & ((instr_word_t'(1) << ra_w) - instr_word_t'(1));
    endfunction

    function automatic instr_word_t instr_imm(input instr_word_t w, input int data_w);
        return w & ((instr_word_t'(1) << data_w) - instr_word_t'(1));
    endfunction

    function automatic logic writes_rd(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
                          OP_LDI, OP_ADDI, OP_SHL, OP_SHR};
    endfunction

endpackage

// File: rtl/cpu_if.sv
// rtl/cpu_if.sv - instruction fetch, result handshake and status bundle of cpu_core
interface cpu_if #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [DATA_W-1:0]  data_out;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         flags;
    logic               halted;

    modport master (
        input  en, imem_rdata, out_ready,
        output imem_addr, data_out, out_valid, flags, halted
    );

    modport slave (
        output en, imem_rdata, out_ready,
        input  imem_addr, data_out, out_valid, flags, halted
    );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: opcode and operands to result, carry and zero
module alu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);
    logic [DATA_W:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            // The extra top bit of the difference is the unsigned borrow
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~b;
            OP_LDI: result = b;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: ;
        endcase
        zero = (result == '0);
    end
endmodule

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - multi-cycle FETCH/DECODE/EXEC core with register file, flags, PC and OUT handshake
module cpu_core
    import cpu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int REG_CNT = 4,
    parameter  int PC_W    = 8,
    localparam int RA_W    = $clog2(REG_CNT),
    localparam int INSTR_W = 4 + 2 * RA_W + DATA_W
) (
    input  logic  clk,
    input  logic  rst,
    cpu_if.master bus
);
    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  regs_q [REG_CNT];
    logic [DATA_W-1:0]  regs_d [REG_CNT];
    logic [1:0]         flags_q, flags_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;
    logic               halted_q, halted_d;

    instr_word_t       ir_ext;
    opcode_e           op;
    logic [RA_W-1:0]   rd, rs;
    logic [DATA_W-1:0] imm, alu_b, alu_result;
    logic              alu_carry, alu_zero;
    logic [PC_W-1:0]   target;

    assign ir_ext = instr_word_t'(ir_q);
    assign op     = instr_op(ir_ext, INSTR_W);
    assign rd     = RA_W'(instr_rd(ir_ext, RA_W, DATA_W));
    assign rs     = RA_W'(instr_rs(ir_ext, RA_W, DATA_W));
    assign imm    = DATA_W'(instr_imm(ir_ext, DATA_W));
    assign target = imm[PC_W-1:0];
    assign alu_b  = (op == OP_LDI || op == OP_ADDI) ? imm : regs_q[rs];

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (regs_q[rd]),
        .b      (alu_b),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        flags_d     = flags_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        // With en low nothing moves, including a pending handshake
        if (bus.en) begin
            if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
            case (state_q)
                FETCH:  state_d = DECODE;
                DECODE: begin
                    ir_d    = bus.imem_rdata;
                    state_d = EXEC;
                end
                EXEC: begin
                    state_d = FETCH;
                    pc_d    = pc_q + PC_W'(1);
                    if (writes_rd(op)) begin
                        regs_d[rd]      = alu_result;
                        flags_d[FLAG_Z] = alu_zero;
                        if (op != OP_LDI) flags_d[FLAG_C] = alu_carry;
                    end
                    case (op)
                        OP_JMP: pc_d = target;
                        OP_JZ:  if (flags_q[FLAG_Z]) pc_d = target;
                        OP_JC:  if (flags_q[FLAG_C]) pc_d = target;
                        OP_OUT: begin
                            data_out_d  = regs_q[rd];
                            out_valid_d = 1'b1;
                            if (!bus.out_ready) state_d = OUT_WAIT;
                        end
                        OP_HALT: begin
                            pc_d     = pc_q;
                            halted_d = 1'b1;
                            state_d  = HALT;
                        end
                        default: ;
                    endcase
                end
                OUT_WAIT: if (bus.out_ready) state_d = FETCH;
                HALT:     ;
                default:  state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            flags_q     <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            flags_q     <= flags_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            regs_q      <= regs_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.flags     = flags_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - directed self-checking bench for cpu_core (8-bit and 16-bit builds)
module tb_cpu_core;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, rst16, en8, en16, ready8, ready16;
    logic [15:0] mem8  [256];
    logic [25:0] mem16 [256];
    logic [15:0] rdata8;
    logic [25:0] rdata16;

    int          passed = 0;
    int          total  = 0;
    logic [15:0] outs [$];
    int          halt_cyc;
    int          valid_cnt;

    cpu_if #(.DATA_W(8),  .PC_W(8), .INSTR_W(16)) b8 ();
    cpu_if #(.DATA_W(16), .PC_W(8), .INSTR_W(26)) b16 ();

    assign b8.en          = en8;
    assign b8.out_ready   = ready8;
    assign b8.imem_rdata  = rdata8;
    assign b16.en         = en16;
    assign b16.out_ready  = ready16;
    assign b16.imem_rdata = rdata16;

    always_ff @(posedge clk) rdata8  <= mem8[b8.imem_addr];
    always_ff @(posedge clk) rdata16 <= mem16[b16.imem_addr];

    cpu_core #(.DATA_W(8), .REG_CNT(4), .PC_W(8)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (b8)
    );

    cpu_core #(.DATA_W(16), .REG_CNT(8), .PC_W(8)) dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (b16)
    );

    function automatic logic [15:0] enc8(input opcode_e op, input logic [1:0] rd,
                                         input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [25:0] enc16(input opcode_e op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic clear8();
        for (int i = 0; i < 256; i++) mem8[i] = '0;
    endtask

    task automatic clear16();
        for (int i = 0; i < 256; i++) mem16[i] = '0;
    endtask

    task automatic reset8();
        rst8 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
    endtask

    task automatic reset16();
        rst16 = 1'b0;
        repeat (2) @(negedge clk);
        rst16 = 1'b1;
    endtask

    task automatic run8(input int max_cycles);
        outs.delete();
        halt_cyc  = -1;
        valid_cnt = 0;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            if (b8.out_valid) valid_cnt++;
            if (b8.out_valid && ready8 && en8) outs.push_back(16'(b8.data_out));
            if (b8.halted) begin
                halt_cyc = k;
                break;
            end
        end
    endtask

    task automatic run16(input int max_cycles);
        outs.delete();
        halt_cyc  = -1;
        valid_cnt = 0;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            if (b16.out_valid) valid_cnt++;
            if (b16.out_valid && ready16 && en16) outs.push_back(b16.data_out);
            if (b16.halted) begin
                halt_cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst8 = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (b8.imem_addr !== 8'h00) $display("FAIL reset_addr: got %0h expected 0", b8.imem_addr); else passed++;
        total++; if (b8.data_out !== 8'h00) $display("FAIL reset_data: got %0h expected 0", b8.data_out); else passed++;
        total++; if (b8.out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", b8.out_valid); else passed++;
        total++; if (b8.halted !== 1'b0) $display("FAIL reset_halted: got %0b expected 0", b8.halted); else passed++;
        total++; if (b8.flags !== 2'b00) $display("FAIL reset_flags: got %0b expected 00", b8.flags); else passed++;
    endtask

    task automatic test_basic();
        clear8();
        mem8[0] = enc8(OP_LDI, 2'd0, 2'd0, 8'd5);
        mem8[1] = enc8(OP_LDI, 2'd1, 2'd0, 8'd3);
        mem8[2] = enc8(OP_ADD, 2'd0, 2'd1, 8'd0);
        mem8[3] = enc8(OP_OUT, 2'd0, 2'd0, 8'd0);
        mem8[4] = enc8(OP_HALT, 2'd0, 2'd0, 8'd0);
        reset8();
        run8(40);
        total++; if (halt_cyc != 15) $display("FAIL basic_halt_cycle: got %0d expected 15", halt_cyc); else passed++;
        total++; if (outs.size() != 1) $display("FAIL basic_out_count: got %0d expected 1", outs.size()); else passed++;
        total++; if (outs.size() > 0 && outs[0] !== 16'd8) $display("FAIL basic_out_data: got %0h expected 8", outs[0]); else passed++;
        total++; if (valid_cnt != 1) $display("FAIL basic_valid_pulse: got %0d expected 1", valid_cnt); else passed++;
        total++; if (b8.flags !== 2'b00) $display("FAIL basic_flags: got %0b expected 00", b8.flags); else passed++;
        total++; if (b8.imem_addr !== 8'h04) $display("FAIL basic_halt_addr: got %0h expected 4", b8.imem_addr); else passed++;
    endtask

    task automatic test_arith();
        clear8();
        mem8[0] = enc8(OP_LDI, 2'd0, 2'd0, 8'hFF);
        mem8[1] = enc8(OP_ADDI, 2'd0, 2'd0, 8'h01);
        mem8[2] = enc8(OP_OUT, 2'd0, 2'd0, 8'h00);
        mem8[3] = enc8(OP_HALT, 2'd0, 2'd0, 8'h00);
        reset8();
        run8(60);
        total++; if (outs.size() != 1 || outs[0] !== 16'h00) $display("FAIL addi_wrap_result: got %0h (n=%0d) expected 0", outs.size() > 0 ? outs[0] : 16'hFFFF, outs.size()); else passed++;
        total++; if (b8.flags !== 2'b11) $display("FAIL addi_wrap_flags: got %0b expected 11", b8.flags); else passed++;

        clear8();
        mem8[0] = enc8(OP_LDI, 2'd2, 2'd0, 8'd1);
        mem8[1] = enc8(OP_LDI, 2'd3, 2'd0, 8'd2);
        mem8[2] = enc8(OP_SUB, 2'd2, 2'd3, 8'd0);
        mem8[3] = enc8(OP_OUT, 2'd2, 2'd0, 8'd0);
        mem8[4] = enc8(OP_HALT, 2'd0, 2'd0, 8'd0);
        reset8();
        run8(60);
        total++; if (outs.size() != 1 || outs[0] !== 16'hFF) $display("FAIL sub_borrow_result: got %0h (n=%0d) expected ff", outs.size() > 0 ? outs[0] : 16'hFFFF, outs.size()); else passed++;
        total++; if (b8.flags !== 2'b10) $display("FAIL sub_borrow_flags: got %0b expected 10", b8.flags); else passed++;

        clear8();
        mem8[0] = enc8(OP_LDI, 2'd1, 2'd0, 8'd7);
        mem8[1] = enc8(OP_SUB, 2'd1, 2'd1, 8'd0);
        mem8[2] = enc8(OP_OUT, 2'd1, 2'd0, 8'd0);
        mem8[3] = enc8(OP_HALT, 2'd0, 2'd0, 8'd0);
        reset8();
        run8(60);
        total++; if (outs.size() != 1 || outs[0] !== 16'h00) $display("FAIL sub_self_result: got %0h (n=%0d) expected 0", outs.size() > 0 ? outs[0] : 16'hFFFF, outs.size()); else passed++;
        total++; if (b8.flags !== 2'b01) $display("FAIL sub_self_flags: got %0b expected 01", b8.flags); else passed++;

        clear8();
        mem8[0] = enc8(OP_LDI, 2'd0, 2'd0, 8'h81);
        mem8[1] = enc8(OP_SHR, 2'd0, 2'd0, 8'h00);
        mem8[2] = enc8(OP_OUT, 2'd0, 2'd0, 8'h00);
        mem8[3] = enc8(OP_LDI, 2'd1, 2'd0, 8'hF0);
        mem8[4] = enc8(OP_AND, 2'd1, 2'd0, 8'h00);
        mem8[5] = enc8(OP_OUT, 2'd1, 2'd0, 8'h00);
        mem8[6] = enc8(OP_NOT, 2'd2, 2'd1, 8'h00);
        mem8[7] = enc8(OP_OUT, 2'd2, 2'd0, 8'h00);
        mem8[8] = enc8(OP_HALT, 2'd0, 2'd0, 8'h00);
        reset8();
        run8(80);
        total++; if (outs.size() != 3 || {outs[0], outs[1], outs[2]} !== {16'h40, 16'h40, 16'hBF}) $display("FAIL shr_and_not_results: n=%0d expected 40,40,bf", outs.size()); else passed++;
        total++; if (b8.flags !== 2'b00) $display("FAIL shr_and_not_flags: got %0b expected 00", b8.flags); else passed++;

        clear8();
        mem8[0] = enc8(OP_LDI, 2'd3, 2'd0, 8'h81);
        mem8[1] = enc8(OP_SHL, 2'd3, 2'd0, 8'h00);
        mem8[2] = enc8(OP_OUT, 2'd3, 2'd0, 8'h00);
        mem8[3] = enc8(OP_HALT, 2'd0, 2'd0, 8'h00);
        reset8();
        run8(60);
        total++; if (outs.size() != 1 || outs[0] !== 16'h02) $display("FAIL shl_result: got %0h (n=%0d) expected 2", outs.size() > 0 ? outs[0] : 16'hFFFF, outs.size()); else passed++;
        total++; if (b8.flags !== 2'b10) $display("FAIL shl_flags: got %0b expected 10", b8.flags); else passed++;
    endtask

    task automatic test_jumps();
        clear8();
        mem8[0] = enc8(OP_LDI, 2'd0, 2'd0, 8'h00);
        mem8[1] = enc8(OP_JZ, 2'd0, 2'd0, 8'h10);
        reset8();
        repeat (6) @(negedge clk);
        total++; if (b8.imem_addr !== 8'h10) $display("FAIL jz_taken: got %0h expected 10", b8.imem_addr); else passed++;

        clear8();
        mem8[0] = enc8(OP_LDI, 2'd0, 2'd0, 8'h01);
        mem8[1] = enc8(OP_JZ, 2'd0, 2'd0, 8'h10);
        reset8();
        repeat (6) @(negedge clk);
        total++; if (b8.imem_addr !== 8'h02) $display("FAIL jz_not_taken: got %0h expected 2", b8.imem_addr); else passed++;

        clear8();
        mem8[0] = enc8(OP_LDI, 2'd0, 2'd0, 8'hFF);
        mem8[1] = enc8(OP_ADDI, 2'd0, 2'd0, 8'h01);
        mem8[2] = enc8(OP_JC, 2'd0, 2'd0, 8'h20);
        reset8();
        repeat (6) @(negedge clk);
        total++; if (b8.flags !== 2'b11) $display("FAIL addi_flags_visible: got %0b expected 11", b8.flags); else passed++;
        repeat (3) @(negedge clk);
        total++; if (b8.imem_addr !== 8'h20) $display("FAIL jc_taken: got %0h expected 20", b8.imem_addr); else passed++;

        clear8();
        mem8[0]   = enc8(OP_JMP, 2'd0, 2'd0, 8'hFF);
        mem8[255] = enc8(OP_NOP, 2'd0, 2'd0, 8'h00);
        reset8();
        repeat (3) @(negedge clk);
        total++; if (b8.imem_addr !== 8'hFF) $display("FAIL jmp_target: got %0h expected ff", b8.imem_addr); else passed++;
        repeat (3) @(negedge clk);
        total++; if (b8.imem_addr !== 8'h00) $display("FAIL pc_wrap: got %0h expected 0", b8.imem_addr); else passed++;
    endtask

    task automatic test_out_stall();
        clear8();
        mem8[0] = enc8(OP_LDI, 2'd0, 2'd0, 8'h5A);
        mem8[1] = enc8(OP_OUT, 2'd0, 2'd0, 8'h00);
        mem8[2] = enc8(OP_HALT, 2'd0, 2'd0, 8'h00);
        ready8 = 1'b0;
        reset8();
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (b8.out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %0b expected 1", i, b8.out_valid); else passed++;
            total++; if (b8.data_out !== 8'h5A) $display("FAIL stall_data[%0d]: got %0h expected 5a", i, b8.data_out); else passed++;
            total++; if (b8.imem_addr !== 8'h02) $display("FAIL stall_addr[%0d]: got %0h expected 2", i, b8.imem_addr); else passed++;
        end
        ready8 = 1'b1;
        @(negedge clk);
        total++; if (b8.out_valid !== 1'b0) $display("FAIL stall_release_valid: got %0b expected 0", b8.out_valid); else passed++;
        total++; if (b8.halted !== 1'b0) $display("FAIL stall_resume_early_halt: got %0b expected 0", b8.halted); else passed++;
        repeat (3) @(negedge clk);
        total++; if (b8.halted !== 1'b1) $display("FAIL stall_resume_halt: got %0b expected 1", b8.halted); else passed++;
        total++; if (b8.imem_addr !== 8'h02) $display("FAIL stall_halt_addr: got %0h expected 2", b8.imem_addr); else passed++;
    endtask

    task automatic test_en_reset();
        clear8();
        mem8[0] = enc8(OP_LDI, 2'd0, 2'd0, 8'h09);
        mem8[1] = enc8(OP_OUT, 2'd0, 2'd0, 8'h00);
        mem8[2] = enc8(OP_LDI, 2'd1, 2'd0, 8'h01);
        mem8[3] = enc8(OP_HALT, 2'd0, 2'd0, 8'h00);
        ready8 = 1'b1;
        reset8();
        repeat (6) @(negedge clk);
        total++; if (b8.out_valid !== 1'b1) $display("FAIL en_pre_valid: got %0b expected 1", b8.out_valid); else passed++;
        en8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({b8.out_valid, b8.data_out, b8.imem_addr, b8.halted} !== {1'b1, 8'h09, 8'h02, 1'b0})
                $display("FAIL en_frozen[%0d]: got v=%0b d=%0h a=%0h h=%0b expected v=1 d=9 a=2 h=0",
                         i, b8.out_valid, b8.data_out, b8.imem_addr, b8.halted);
            else passed++;
        end
        en8 = 1'b1;
        @(negedge clk);
        total++; if (b8.out_valid !== 1'b0) $display("FAIL en_resume_accept: got %0b expected 0", b8.out_valid); else passed++;
        @(negedge clk);
        total++; if (b8.data_out !== 8'h09) $display("FAIL pre_reset_data: got %0h expected 9", b8.data_out); else passed++;
        rst8 = 1'b0;
        #1;
        total++; if (b8.imem_addr !== 8'h00) $display("FAIL midexec_reset_addr: got %0h expected 0", b8.imem_addr); else passed++;
        total++; if (b8.data_out !== 8'h00) $display("FAIL midexec_reset_data: got %0h expected 0", b8.data_out); else passed++;
        total++; if ({b8.out_valid, b8.halted, b8.flags} !== 4'b0000) $display("FAIL midexec_reset_status: got %0b expected 0000", {b8.out_valid, b8.halted, b8.flags}); else passed++;
        clear8();
        mem8[0] = enc8(OP_OUT, 2'd0, 2'd0, 8'h00);
        mem8[1] = enc8(OP_HALT, 2'd0, 2'd0, 8'h00);
        @(negedge clk);
        rst8 = 1'b1;
        run8(20);
        total++; if (halt_cyc != 6) $display("FAIL post_reset_halt_cycle: got %0d expected 6", halt_cyc); else passed++;
        total++; if (outs.size() != 1 || outs[0] !== 16'h00) $display("FAIL post_reset_reg_clear: got %0h (n=%0d) expected 0", outs.size() > 0 ? outs[0] : 16'hFFFF, outs.size()); else passed++;
    endtask

    task automatic test_wide16();
        clear16();
        mem16[0] = enc16(OP_LDI, 3'd0, 3'd0, 16'd5);
        mem16[1] = enc16(OP_LDI, 3'd1, 3'd0, 16'd3);
        mem16[2] = enc16(OP_ADD, 3'd0, 3'd1, 16'd0);
        mem16[3] = enc16(OP_OUT, 3'd0, 3'd0, 16'd0);
        mem16[4] = enc16(OP_HALT, 3'd0, 3'd0, 16'd0);
        reset16();
        run16(40);
        total++; if (halt_cyc != 15) $display("FAIL w16_halt_cycle: got %0d expected 15", halt_cyc); else passed++;
        total++; if (outs.size() != 1 || outs[0] !== 16'd8) $display("FAIL w16_out: got %0h (n=%0d) expected 8", outs.size() > 0 ? outs[0] : 16'hFFFF, outs.size()); else passed++;
        total++; if (b16.flags !== 2'b00) $display("FAIL w16_flags: got %0b expected 00", b16.flags); else passed++;

        clear16();
        mem16[0] = enc16(OP_LDI, 3'd5, 3'd0, 16'h8000);
        mem16[1] = enc16(OP_ADD, 3'd5, 3'd5, 16'h0000);
        mem16[2] = enc16(OP_OUT, 3'd5, 3'd0, 16'h0000);
        mem16[3] = enc16(OP_HALT, 3'd0, 3'd0, 16'h0000);
        reset16();
        run16(40);
        total++; if (halt_cyc != 12) $display("FAIL w16_self_add_halt: got %0d expected 12", halt_cyc); else passed++;
        total++; if (outs.size() != 1 || outs[0] !== 16'h0000) $display("FAIL w16_self_add_out: got %0h (n=%0d) expected 0", outs.size() > 0 ? outs[0] : 16'hFFFF, outs.size()); else passed++;
        total++; if (b16.flags !== 2'b11) $display("FAIL w16_self_add_flags: got %0b expected 11", b16.flags); else passed++;
    endtask

    initial begin
        rst8    = 1'b0;
        rst16   = 1'b0;
        en8     = 1'b1;
        en16    = 1'b1;
        ready8  = 1'b1;
        ready16 = 1'b1;
        clear8();
        clear16();
        test_reset();
        test_basic();
        test_arith();
        test_jumps();
        test_out_stall();
        test_en_reset();
        test_wide16();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
